// File: rtl/medidor_frec_secuenciador.sv
// medidor_frec_secuenciador: steps the oscillator select, sums 2^AVG_LOG2 meter captures per index, streams one result per index
module medidor_frec_secuenciador #(
  parameter int OUT_WIDTH     = 32,
  parameter int SEL_WIDTH     = 4,
  parameter int AVG_LOG2      = 2,
  parameter int SETTLE_CYCLES = 16,
  parameter int DRAIN_TIMEOUT = 1024
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          continuous,
  input  logic [SEL_WIDTH-1:0]          osc_first,
  input  logic [SEL_WIDTH-1:0]          osc_last,
  input  logic [4:0]                    resol_in,
  input  logic                          stop,
  output logic [SEL_WIDTH-1:0]          osc_sel,
  output logic                          meter_enable,
  output logic [4:0]                    meter_resol,
  input  logic                          meter_lock,
  input  logic [OUT_WIDTH-1:0]          meter_out,
  output logic [OUT_WIDTH+AVG_LOG2-1:0] m_data,
  output logic [SEL_WIDTH-1:0]          m_osc,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic                          busy,
  output logic                          err_timeout
);
  localparam logic [2:0] IDLE = 3'd0, SETTLE = 3'd1, ARM = 3'd2, DRAIN = 3'd3, EMIT = 3'd4;
  localparam int CW = $clog2(SETTLE_CYCLES + DRAIN_TIMEOUT + 1);
  localparam int NM = (1 << AVG_LOG2) - 1;
  logic [2:0] state;
  logic [CW-1:0] cnt;
  logic [AVG_LOG2:0] meas;
  logic [SEL_WIDTH-1:0] first, last;
  logic cont, stop_f, last_idx, done;
  assign m_valid  = state == EMIT;
  assign busy     = state != IDLE;
  assign m_osc    = osc_sel;
  assign last_idx = osc_sel == last;
  assign done     = stop_f || stop || (last_idx && !cont);
  // m_data doubles as the accumulator; it is stable throughout EMIT
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      osc_sel      <= '0;
      meter_resol  <= '0;
      m_data       <= '0;
      meter_enable <= 1'b0;
      err_timeout  <= 1'b0;
      cnt          <= '0;
      meas         <= '0;
      first        <= '0;
      last         <= '0;
      cont         <= 1'b0;
      stop_f       <= 1'b0;
    end else begin
      if (stop && busy) stop_f <= 1'b1;
      case (state)
        IDLE: if (start) begin
          first       <= osc_first;
          last        <= osc_last;
          cont        <= continuous;
          meter_resol <= resol_in;
          osc_sel     <= osc_first;
          m_data      <= '0;
          meas        <= '0;
          cnt         <= '0;
          err_timeout <= 1'b0;
          stop_f      <= stop;
          state       <= SETTLE;
        end
        SETTLE: if (cnt == CW'(SETTLE_CYCLES - 1)) begin
          cnt          <= '0;
          meter_enable <= 1'b1;
          state        <= ARM;
        end else cnt <= cnt + 1'b1;
        // capture only on the first lock cycle; meter_out keeps moving afterwards
        ARM: if (meter_lock) begin
          m_data       <= m_data + (OUT_WIDTH + AVG_LOG2)'(meter_out);
          meter_enable <= 1'b0;
          cnt          <= '0;
          state        <= DRAIN;
        end
        DRAIN: if (!meter_lock) begin
          if (meas == (AVG_LOG2 + 1)'(NM)) state <= EMIT;
          else begin
            meas         <= meas + 1'b1;
            meter_enable <= 1'b1;
            state        <= ARM;
          end
        end else if (cnt == CW'(DRAIN_TIMEOUT - 1)) begin
          err_timeout <= 1'b1;
          m_data      <= '0;
          state       <= IDLE;
        end else cnt <= cnt + 1'b1;
        EMIT: if (m_ready) begin
          m_data <= '0;
          meas   <= '0;
          cnt    <= '0;
          if (done) state <= IDLE;
          else begin
            osc_sel <= last_idx ? first : osc_sel + 1'b1;
            state   <= SETTLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
